// File: rtl/simon_data_out.sv
// Collects one or two SIMON result blocks from the cipher core and frames them as a byte packet
// with a sequence count and an info byte, holding the packet until downstream takes it.
module simon_data_out #(
    parameter int unsigned N    = 16,
    parameter logic [3:0]  MODE = 4'h0
) (
    input  logic                      clk,
    input  logic                      R,
    input  logic                      doneDATA,
    input  logic [1:0][N-1:0]         outDATA,
    input  logic                      lastBLOCK,
    input  logic                      loadPKT,
    output logic                      loadDATA,
    output logic                      newPKT,
    output logic [(1+N/2):0][7:0]     out,
    output logic [7:0]                countOUT
);

    typedef enum logic [1:0] {StIdle, StCapture, StPack, StSend} state_e;

    state_e                  state_q, state_d;
    logic                    slot_q, slot_d;
    logic                    last_q, last_d;
    logic [4*N-1:0]          data_q, data_d;
    logic                    load_q, load_d;
    logic                    newpkt_q, newpkt_d;
    logic [(1+N/2):0][7:0]   out_q, out_d;
    logic [7:0]              count_q, count_d;
    logic [4*N-1:0]          pk_data;
    logic [7:0]              info;

    // A lone block leaves slot 1 empty; stale words from an earlier packet must not leak out.
    always_comb begin
        pk_data = slot_q ? data_q : {{(2*N){1'b0}}, data_q[2*N-1:0]};
        info    = {slot_q, 1'b0, 1'b0, 1'b1, MODE};
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        last_d   = last_q;
        data_d   = data_q;
        load_d   = load_q;
        newpkt_d = newpkt_q;
        out_d    = out_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (doneDATA) begin
                    if (slot_q) begin
                        data_d[4*N-1:2*N] = outDATA;
                    end else begin
                        data_d[2*N-1:0] = outDATA;
                    end
                    last_d  = lastBLOCK;
                    load_d  = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                load_d = 1'b0;
                if (!slot_q && !last_q) begin
                    slot_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StPack;
                end
            end
            StPack: begin
                out_d    = {info, count_q, pk_data};
                newpkt_d = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                // Release wins over a waiting doneDATA; the capture happens from IDLE next edge.
                if (loadPKT) begin
                    newpkt_d = 1'b0;
                    count_d  = count_q + 8'd1;
                    slot_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q  <= StIdle;
            slot_q   <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            load_q   <= 1'b0;
            newpkt_q <= 1'b0;
            out_q    <= '0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            last_q   <= last_d;
            data_q   <= data_d;
            load_q   <= load_d;
            newpkt_q <= newpkt_d;
            out_q    <= out_d;
            count_q  <= count_d;
        end
    end

    assign loadDATA = load_q;
    assign newPKT   = newpkt_q;
    assign out      = out_q;
    assign countOUT = count_q;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed and randomized checks of simon_data_out (N=16, MODE=3) against a packet-level model.
module tb_simon_data_out;

    localparam int unsigned N    = 16;
    localparam logic [3:0]  MODE = 4'h3;

    logic                  clk = 1'b0;
    logic                  R;
    logic                  doneDATA;
    logic [1:0][N-1:0]     outDATA;
    logic                  lastBLOCK;
    logic                  loadPKT;
    logic                  loadDATA;
    logic                  newPKT;
    logic [(1+N/2):0][7:0] out;
    logic [7:0]            countOUT;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] count_m;

    always #5 clk = ~clk;

    simon_data_out #(.N(N), .MODE(MODE)) dut (
        .clk       (clk),
        .R         (R),
        .doneDATA  (doneDATA),
        .outDATA   (outDATA),
        .lastBLOCK (lastBLOCK),
        .loadPKT   (loadPKT),
        .loadDATA  (loadDATA),
        .newPKT    (newPKT),
        .out       (out),
        .countOUT  (countOUT)
    );

    // Packet = info byte, count byte, then block 0 in the low words and block 1 above it.
    function automatic logic [79:0] exp_pkt(input int nb, input logic [31:0] b0,
                                            input logic [31:0] b1, input logic [7:0] c);
        logic [63:0] d;
        logic [7:0]  inf;
        d   = (nb == 2) ? {b1, b0} : {32'h0, b0};
        inf = 8'h10 | {4'h0, MODE} | ((nb == 2) ? 8'h80 : 8'h00);
        return {inf, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load"}, loadDATA, 1'b0);
        chk({tag, "_newpkt"}, newPKT, 1'b0);
        chk({tag, "_out"}, out, 80'h0);
        chk({tag, "_count"}, countOUT, 8'h00);
    endtask

    // Offer one block; loadPKT is scrambled since it must be ignored outside SEND.
    task automatic capture(input logic [31:0] blk, input bit last);
        int n;
        n         = 0;
        outDATA   = blk;
        lastBLOCK = last;
        doneDATA  = 1'b1;
        loadPKT   = 1'($urandom);
        do begin
            tick();
            n++;
        end while (!loadDATA && n < 30);
        chk("load_seen", loadDATA, 1'b1);
        doneDATA  = 1'b0;
        lastBLOCK = 1'($urandom);
        outDATA   = 32'($urandom);
        tick();
        chk("load_pulse", loadDATA, 1'b0);
        chk("count_idle", countOUT, count_m);
    endtask

    task automatic release_pkt(input logic [79:0] e);
        loadPKT = 1'b1;
        tick();
        loadPKT = 1'b0;
        count_m = count_m + 8'd1;
        chk("rel_newpkt", newPKT, 1'b0);
        chk("rel_count", countOUT, count_m);
        chk("rel_out", out, e);
    endtask

    task automatic run_pkt(input int nb, input logic [31:0] b0, input logic [31:0] b1,
                           input int hold);
        logic [79:0] e;
        e = exp_pkt(nb, b0, b1, count_m);
        capture(b0, nb == 1);
        if (nb == 2) capture(b1, 1'b1);
        loadPKT = 1'b0;
        chk("pack_wait", newPKT, 1'b0);
        tick();
        chk("pkt_valid", newPKT, 1'b1);
        chk("pkt_out", out, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", newPKT, 1'b1);
            chk("hold_out", out, e);
        end
        release_pkt(e);
    endtask

    initial begin
        logic [79:0] e;
        logic [79:0] e2;
        R         = 1'b1;
        doneDATA  = 1'b0;
        lastBLOCK = 1'b0;
        loadPKT   = 1'b0;
        outDATA   = '0;
        count_m   = 8'h00;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        R = 1'b0;

        // Two-block packet, then a lone block.
        run_pkt(2, 32'h11112222, 32'h33334444, 3);
        run_pkt(1, 32'hABCD0123, 32'h0, 1);

        // Back-pressure with doneDATA waiting, then release priority.
        e = exp_pkt(1, 32'h5555AAAA, 32'h0, count_m);
        capture(32'h5555AAAA, 1'b1);
        loadPKT = 1'b0;
        tick();
        chk("bp_start", newPKT, 1'b1);
        outDATA   = 32'h0F0F1234;
        lastBLOCK = 1'b1;
        doneDATA  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_load", loadDATA, 1'b0);
            chk("bp_valid", newPKT, 1'b1);
            chk("bp_out", out, e);
        end
        loadPKT = 1'b1;
        tick();
        loadPKT = 1'b0;
        count_m = count_m + 8'd1;
        chk("prio_newpkt", newPKT, 1'b0);
        chk("prio_load", loadDATA, 1'b0);
        chk("prio_count", countOUT, count_m);
        tick();
        chk("prio_capture", loadDATA, 1'b1);
        doneDATA = 1'b0;
        e2 = exp_pkt(1, 32'h0F0F1234, 32'h0, count_m);
        tick();
        chk("prio_pulse", loadDATA, 1'b0);
        tick();
        chk("prio_valid", newPKT, 1'b1);
        chk("prio_out", out, e2);
        release_pkt(e2);

        // Reset while a packet is pending in SEND.
        capture(32'h12345678, 1'b1);
        loadPKT = 1'b0;
        tick();
        chk("pre_rst_valid", newPKT, 1'b1);
        R = 1'b1;
        #1;
        chk_reset_outputs("rst_send");
        @(negedge clk);
        R       = 1'b0;
        count_m = 8'h00;
        run_pkt(1, 32'hCAFEBEEF, 32'h0, 0);

        // Reset with only slot 0 collected; the stale half must be dropped.
        capture(32'hDEAD0001, 1'b0);
        R = 1'b1;
        #1;
        chk_reset_outputs("rst_slot0");
        @(negedge clk);
        R       = 1'b0;
        count_m = 8'h00;
        run_pkt(1, 32'h600DF00D, 32'h0, 0);

        // Count wrap over 257 random packets.
        R = 1'b1;
        #1;
        @(negedge clk);
        R       = 1'b0;
        count_m = 8'h00;
        for (int p = 0; p < 257; p++) begin
            run_pkt(1 + int'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                    int'($urandom_range(0, 2)));
        end
        chk("final_count", countOUT, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simon_data_out.md
SIMON_DATA_OUT -- requirements
Module: SIMON_dataOUT

Interface
REQ-001 SHALL have parameter N, default 16: cipher word width in bits; multiple of 8, 16..64.
REQ-002 SHALL have parameter MODE, default 4'h0: cipher mode code written to info[3:0].
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port R, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port doneDATA, input, 1: core result valid; held high until loadDATA is seen.
REQ-006 SHALL have port outDATA, input, [1:0][N-1:0]: core result block of two words.
REQ-007 SHALL have port lastBLOCK, input, 1: the current block ends the stream; the packet is sent with one block.
REQ-008 SHALL have port loadPKT, input, 1: downstream has taken the packet.
REQ-009 SHALL have port loadDATA, output, 1: one-cycle acknowledge to the core.
REQ-010 SHALL have port newPKT, output, 1: packet on out is valid.
REQ-011 SHALL have port out, output, [(1+N/2):0][7:0]: output packet; bytes N/2-1..0 data, byte N/2 count, byte N/2+1 info.
REQ-012 SHALL have port countOUT, output, [7:0]: count of packets sent.

Function
REQ-013 SHALL implement states IDLE, CAPTURE, PACK, SEND.
REQ-014 IDLE, doneDATA=1: SHALL latch outDATA into the current slot, set loadDATA=1 and move to CAPTURE on the same edge.
- Slot 0 is words 0,1 (bytes N/4-1..0).
- Slot 1 is words 2,3 (bytes N/2-1..N/4).
REQ-015 CAPTURE: SHALL clear loadDATA, so loadDATA is high for exactly one cycle, and SHALL ignore doneDATA.
REQ-016 CAPTURE, slot 0 and lastBLOCK=0: SHALL set slot to 1 and return to IDLE.
REQ-017 CAPTURE, otherwise: SHALL go to PACK; lastBLOCK is sampled at the capture edge.
REQ-018 PACK: SHALL drive out and then set newPKT=1, then go to SEND. Field values:
- data slots: as captured; an unused slot 1 is all zeros.
- byte N/2: countOUT.
- info[3:0] = MODE.
- info[4] = 1 (output packet).
- info[5] = 0 (data, not key).
- info[6] = 0.
- info[7] = 1 when two blocks are present.
REQ-019 SEND: SHALL hold out and newPKT stable and SHALL NOT acknowledge doneDATA (back-pressure).
REQ-020 SEND, loadPKT=1: on that edge SHALL do all of the following:
- clear newPKT;
- increment countOUT, modulo 256 (255 -> 0);
- reset slot to 0;
- go to IDLE.
REQ-021 SHALL give a latency of 3 edges from the edge sampling doneDATA=1 in IDLE for a single-block packet to newPKT=1.
REQ-022 loadPKT and doneDATA both high in SEND: SHALL give release priority; the capture SHALL occur no earlier than the next edge, from IDLE.
REQ-023 SHALL ignore loadPKT outside SEND.
REQ-024 SHALL leave out unchanged from release until the next PACK.

Reset
REQ-025 R=1, at any time, asynchronously: SHALL set the following:
- state = IDLE, slot = 0;
- loadDATA = 0, newPKT = 0;
- out = 0, countOUT = 0.
REQ-026 Reset mid-operation: SHALL discard a partly collected packet or a pending packet without any acknowledge.
REQ-027 First edge after R falls: SHALL behave as IDLE with no pending data.

Verification
REQ-028 Reset, N=16, MODE=4'h3; block {16'h1111,16'h2222}, lastBLOCK=0; block {16'h3333,16'h4444}, lastBLOCK=1 -> each capture gives a 1-cycle loadDATA; packet data = 1111,2222,3333,4444; count 8'h00; info 8'h93; newPKT high until loadPKT.
REQ-029 Single block {16'hABCD,16'h0123}, lastBLOCK=1 -> info 8'h13; bytes 7..4 = 0; newPKT 3 edges after the doneDATA sample.
REQ-030 Hold loadPKT low 10 cycles with doneDATA high -> loadDATA stays 0 and out stays stable; loadPKT then releases; the next capture is one edge later.
REQ-031 Send 257 packets -> packet 256 carries count 8'h00; countOUT = 8'h01 after the last release.
REQ-032 Assert R while in SEND, and separately after only slot 0 is filled -> all outputs 0 immediately; the next packet carries count 8'h00 with no leftover data.
REQ-033 loadPKT and doneDATA high on the same SEND edge -> newPKT falls and loadDATA stays 0 that edge; loadDATA pulses on the following edge.
